// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the MIPS execute stage.
// Owns HI/LO and requests a pipeline stall while a MULT/DIV is iterating.
//
// state | meaning
// IDLE  | waiting for a start; services MTHI/MTLO
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result committed in HI/LO; stall released so the instruction leaves EX
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             cancel,
    input  logic             mthiE,
    input  logic             mtloE,
    output logic             stall_muldivE,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   origA;
    logic [2*WIDTH-1:0] acc;
    logic               negRes, negRem, divZero;

    logic               startOk, lastIter, isSigned, iterating;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum, divRem, divDiff;
    logic [2*WIDTH-1:0] mulStep, divStep, product;
    logic [WIDTH-1:0]   quot, rem;

    assign iterating = (state == MUL) || (state == DIV);
    assign startOk   = (state == IDLE) && startE && !flushE && !cancel;
    assign lastIter  = (cnt == CNT_W'(WIDTH - 1));
    assign isSigned  = !opE[0];
    assign absA      = (isSigned && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign absB      = (isSigned && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mulStep = {mulSum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign divRem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign divDiff = divRem - {1'b0, operand};
    assign divStep = divDiff[WIDTH] ? {divRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign product = negRes ? -mulStep : mulStep;
    assign quot    = negRes ? -divStep[WIDTH-1:0] : divStep[WIDTH-1:0];
    assign rem     = negRem ? -divStep[2*WIDTH-1:WIDTH] : divStep[2*WIDTH-1:WIDTH];

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (startOk) stateNext = opE[1] ? DIV : MUL;
            MUL, DIV: begin
                if (cancel)        stateNext = IDLE;
                else if (lastIter) stateNext = DONE;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A cancelled operation releases the pipeline in the same cycle the redirect arrives.
    assign stall_muldivE = startOk || (iterating && !cancel);
    assign busy          = iterating;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            operand <= '0;
            origA   <= '0;
            acc     <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (startOk) begin
                        operand <= opE[1] ? absB : absA;
                        acc     <= {{WIDTH{1'b0}}, (opE[1] ? absA : absB)};
                        origA   <= srcaE;
                        negRes  <= isSigned && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        negRem  <= isSigned && srcaE[WIDTH-1];
                        divZero <= (srcbE == '0);
                    end else begin
                        if (mthiE) hi <= srcaE;
                        if (mtloE) lo <= srcaE;
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    acc <= mulStep;
                    if (lastIter && !cancel) {hi, lo} <= product;
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    acc <= divStep;
                    if (lastIter && !cancel) begin
                        lo <= divZero ? '1 : quot;
                        hi <= divZero ? origA : rem;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
